// File: rtl/memory_access_arbiter.sv
// rtl/memory_access_arbiter.sv - registered round-robin arbiter sharing one memory port between fetch and data
// Every output is a flop; the next-value logic below decides grants, completions and watchdog aborts.
module memory_access_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_instr_read,
  input  logic [ADDR_WIDTH-1:0] i_instr_address,
  output logic [DATA_WIDTH-1:0] o_instr_data,
  output logic                  o_instr_ready,
  input  logic                  i_data_read,
  input  logic                  i_data_write,
  input  logic [ADDR_WIDTH-1:0] i_data_address,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  output logic [DATA_WIDTH-1:0] o_data_rdata,
  output logic                  o_data_ready,
  output logic                  o_data_done,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_done,
  output logic                  o_timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, INSTR_RD, DATA_RD, DATA_WR} state_t;
  typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;

  state_t                state, state_d;
  grant_t                last_grant, last_grant_d;
  logic [CW-1:0]         count, count_d;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic                  mem_read_d, mem_write_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic [DATA_WIDTH-1:0] instr_data_d, data_rdata_d;
  logic                  instr_ready_d, data_ready_d, data_done_d, timeout_d;
  logic                  instr_ok, data_ok, grant_instr, grant_data, expired;

  // A request still held during its own completion pulse must not be re-granted.
  assign instr_ok    = i_instr_read && !o_instr_ready;
  assign data_ok     = (i_data_read || i_data_write) && !(o_data_ready || o_data_done);
  assign grant_instr = instr_ok && (!data_ok || (last_grant == GRANT_DATA));
  assign grant_data  = data_ok && !grant_instr;
  assign expired     = WD_EN && (count == LIMIT);

  always_comb begin
    state_d       = state;
    last_grant_d  = last_grant;
    count_d       = count;
    mem_address_d = o_mem_address;
    mem_read_d    = o_mem_read;
    mem_write_d   = o_mem_write;
    mem_wdata_d   = o_mem_wdata;
    instr_data_d  = o_instr_data;
    data_rdata_d  = o_data_rdata;
    instr_ready_d = 1'b0;
    data_ready_d  = 1'b0;
    data_done_d   = 1'b0;
    timeout_d     = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_instr) begin
          state_d       = INSTR_RD;
          last_grant_d  = GRANT_INSTR;
          count_d       = '0;
          mem_address_d = i_instr_address;
          mem_read_d    = 1'b1;
        end else if (grant_data) begin
          last_grant_d  = GRANT_DATA;
          count_d       = '0;
          mem_address_d = i_data_address;
          // A simultaneous read and write services the read; the write waits.
          if (i_data_read) begin
            state_d    = DATA_RD;
            mem_read_d = 1'b1;
          end else begin
            state_d     = DATA_WR;
            mem_write_d = 1'b1;
            mem_wdata_d = i_data_wdata;
          end
        end
      end

      INSTR_RD: begin
        if (i_mem_ready || expired) begin
          state_d       = IDLE;
          mem_read_d    = 1'b0;
          instr_ready_d = 1'b1;
          timeout_d     = !i_mem_ready;
          instr_data_d  = i_mem_ready ? i_mem_rdata : '0;
        end else begin
          count_d = count + CW'(1);
        end
      end

      DATA_RD: begin
        if (i_mem_ready || expired) begin
          state_d      = IDLE;
          mem_read_d   = 1'b0;
          data_ready_d = 1'b1;
          timeout_d    = !i_mem_ready;
          data_rdata_d = i_mem_ready ? i_mem_rdata : '0;
        end else begin
          count_d = count + CW'(1);
        end
      end

      DATA_WR: begin
        if (i_mem_done || expired) begin
          state_d     = IDLE;
          mem_write_d = 1'b0;
          data_done_d = 1'b1;
          timeout_d   = !i_mem_done;
        end else begin
          count_d = count + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_grant    <= GRANT_DATA;
      count         <= '0;
      o_mem_address <= '0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_wdata   <= '0;
      o_instr_data  <= '0;
      o_data_rdata  <= '0;
      o_instr_ready <= 1'b0;
      o_data_ready  <= 1'b0;
      o_data_done   <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      last_grant    <= last_grant_d;
      count         <= count_d;
      o_mem_address <= mem_address_d;
      o_mem_read    <= mem_read_d;
      o_mem_write   <= mem_write_d;
      o_mem_wdata   <= mem_wdata_d;
      o_instr_data  <= instr_data_d;
      o_data_rdata  <= data_rdata_d;
      o_instr_ready <= instr_ready_d;
      o_data_ready  <= data_ready_d;
      o_data_done   <= data_done_d;
      o_timeout     <= timeout_d;
    end
  end

endmodule
